// File: rtl/stream_flip_demapper.sv
// stream_flip_demapper: two-stage valid/ready demapper turning per-symbol flip/rotation/polarity
// flags into a ranked flip index plus packed 2-bit payload, flagging and counting illegal frames.
module stream_flip_demapper #(
    parameter int N_SYM    = 7,
    parameter int MAX_FLIP = 2,
    parameter int ERR_W    = 16,
    localparam int N_PAT   = 1 + N_SYM + ((MAX_FLIP == 2) ? N_SYM * (N_SYM - 1) / 2 : 0),
    localparam int IDX_W   = $clog2(N_PAT),
    localparam int OUT_W   = IDX_W + 2 * N_SYM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_SYM-1:0] in_flip,
    input  logic [N_SYM-1:0] in_rotation,
    input  logic [N_SYM-1:0] in_polarity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int PW    = 2 * N_SYM;
    localparam int CNT_W = $clog2(N_SYM + 1);
    localparam int POS_W = $clog2(N_SYM);

    logic             w_en;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_slot;
    logic [PW-1:0]    w_pay;
    logic [POS_W-1:0] w_i;
    logic [POS_W-1:0] w_j;
    logic             w_got_i;
    logic             w_got_j;
    logic [IDX_W-1:0] w_base;
    logic [IDX_W-1:0] w_idx;
    logic             w_err;

    logic             r1_valid;
    logic [CNT_W-1:0] r1_cnt;
    logic [PW-1:0]    r1_pay;
    logic [POS_W-1:0] r1_i;
    logic [POS_W-1:0] r1_j;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_err;
    logic [ERR_W-1:0] r_err_cnt;

    assign w_en      = !r_out_valid || out_ready;
    assign in_ready  = w_en && !rst;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign err_cnt   = r_err_cnt;

    // Stage 1: weight, lowest two flip positions, and payload of unflipped symbols packed from bit 0
    always_comb begin
        w_cnt   = '0;
        w_slot  = '0;
        w_pay   = '0;
        w_i     = '0;
        w_j     = '0;
        w_got_i = 1'b0;
        w_got_j = 1'b0;
        for (int k = 0; k < N_SYM; k++) begin
            if (in_flip[k]) begin
                w_cnt = w_cnt + CNT_W'(1);
                if (!w_got_i) begin
                    w_i     = POS_W'(k);
                    w_got_i = 1'b1;
                end else if (!w_got_j) begin
                    w_j     = POS_W'(k);
                    w_got_j = 1'b1;
                end
            end else begin
                w_pay[2*w_slot +: 2] = {in_rotation[k], in_polarity[k]};
                w_slot               = w_slot + CNT_W'(1);
            end
        end
    end

    // Stage 2: pair rank = 1 + N_SYM + pairs starting below i + offset of j past i
    always_comb begin
        w_base = '0;
        for (int k = 0; k < N_SYM; k++)
            if (k < int'(r1_i)) w_base = w_base + IDX_W'(N_SYM - 1 - k);
        w_idx = (r1_cnt == CNT_W'(0)) ? '0 :
                (r1_cnt == CNT_W'(1)) ? IDX_W'(1) + IDX_W'(r1_i) :
                IDX_W'(1 + N_SYM) + w_base + IDX_W'(r1_j) - IDX_W'(r1_i) - IDX_W'(1);
        w_err = r1_cnt > CNT_W'(MAX_FLIP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r1_cnt      <= '0;
            r1_pay      <= '0;
            r1_i        <= '0;
            r1_j        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_en) begin
            r1_valid    <= in_valid;
            r1_cnt      <= w_cnt;
            r1_pay      <= w_pay;
            r1_i        <= w_i;
            r1_j        <= w_j;
            r_out_valid <= r1_valid;
            r_out_data  <= w_err ? '0 : {w_idx, r1_pay};
            r_out_err   <= w_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_err_cnt <= '0;
        else if (r_out_valid && out_ready && r_out_err && !(&r_err_cnt))
            r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
endmodule

// File: tb/tb_stream_flip_demapper.sv
// tb_stream_flip_demapper: scoreboard bench for stream_flip_demapper (N_SYM=7, MAX_FLIP=2).
// A second instance with a 2-bit error counter shares the stimulus to exercise saturation.
module tb_stream_flip_demapper;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_flip = '0;
    logic [6:0]  in_rotation = '0;
    logic [6:0]  in_polarity = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [18:0] out_data;
    logic        out_err;
    logic [15:0] err_cnt;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [18:0] s_out_data;
    logic        s_out_err;
    logic [1:0]  s_err_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          n_out = 0;
    logic [19:0] sb[$];
    logic        prev_stall = 1'b0;
    logic [18:0] prev_data = '0;
    logic        sweep_on = 1'b0;
    logic [28:0] seen = '0;

    stream_flip_demapper #(.N_SYM(7), .MAX_FLIP(2), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_flip(in_flip), .in_rotation(in_rotation), .in_polarity(in_polarity),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    stream_flip_demapper #(.N_SYM(7), .MAX_FLIP(2), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_flip(in_flip), .in_rotation(in_rotation), .in_polarity(in_polarity),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_err(s_out_err), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: rank found by enumerating patterns in order rather than by closed form
    function automatic logic [19:0] model(input logic [6:0] f, input logic [6:0] r, input logic [6:0] p);
        logic [13:0] pay;
        logic [6:0]  one;
        int          slot, w, n, idx;
        pay = '0; slot = 0; w = 0; n = 1; idx = 0;
        one = 7'd1;
        for (int k = 0; k < 7; k++) begin
            if (f[k]) w++;
            else begin
                pay[2*slot +: 2] = {r[k], p[k]};
                slot++;
            end
        end
        for (int a = 0; a < 7; a++) begin
            if (f == (one << a)) idx = n;
            n++;
        end
        for (int a = 0; a < 7; a++)
            for (int b = a + 1; b < 7; b++) begin
                if (f == ((one << a) | (one << b))) idx = n;
                n++;
            end
        return (w > 2) ? {1'b1, 19'd0} : {1'b0, 5'(idx), pay};
    endfunction

    task automatic send(input logic [6:0] f, input logic [6:0] r, input logic [6:0] p);
        int t;
        in_flip = f; in_rotation = r; in_polarity = p; in_valid = 1'b1;
        @(negedge clk);
        for (t = 0; t < 200 && !in_ready; t++) @(negedge clk);
        if (!in_ready) check("accept_timeout", 32'(in_ready), 1);
        acc_cyc = cyc;
        sb.push_back(model(f, r, p));
        @(posedge clk); #1;
    endtask

    task automatic one(input string tag, input logic [6:0] f, input logic [6:0] r, input logic [6:0] p,
                       input logic [18:0] exp_data, input logic exp_err);
        int t;
        send(f, r, p);
        in_valid = 1'b0;
        @(negedge clk);
        for (t = 0; t < 50 && !out_valid; t++) @(negedge clk);
        check({tag, "_lat"}, 32'(cyc - acc_cyc), 2);
        check({tag, "_data"}, 32'(out_data), 32'(exp_data));
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
        check("drain", 32'(sb.size()), 0);
        @(posedge clk); #1;
    endtask

    // Output monitor: scoreboard pop on each handshake, stability check while stalled
    always @(negedge clk) begin
        if (rst) prev_stall <= 1'b0;
        else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_underflow", 32'(out_valid), 0);
                else check("sb_frame", 32'({out_err, out_data}), 32'(sb.pop_front()));
                n_out++;
                if (sweep_on) seen[out_data[18:14]] <= 1'b1;
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
        end
    end

    initial begin
        logic [6:0] ff;
        int c0, outs0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_err", 32'(out_err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        one("t1", 7'h00, 7'h7F, 7'h00, 19'h02AAA, 1'b0);
        one("t2", 7'h04, 7'h00, 7'h7F, {5'd3, 14'h0555}, 1'b0);
        one("t3a", 7'h03, 7'h15, 7'h2A, {5'd8, 14'h0000} | 19'(model(7'h03, 7'h15, 7'h2A) & 20'h03FFF), 1'b0);
        one("t3b", 7'h50, 7'h00, 7'h00, {5'd27, 14'h0000}, 1'b0);
        drain();

        sweep_on = 1'b1;
        c0 = -1;
        for (int f = 0; f < 128; f++) begin
            ff = 7'(f);
            if ($countones(ff) <= 2) begin
                send(ff, 7'($urandom), 7'($urandom));
                if (c0 < 0) c0 = acc_cyc;
            end
        end
        check("sweep_rate", 32'(acc_cyc - c0), 28);
        in_valid = 1'b0;
        drain();
        sweep_on = 1'b0;
        check("sweep_unique", 32'(seen), 32'h1FFF_FFFF);

        one("t4", 7'h07, 7'h7F, 7'h7F, 19'd0, 1'b1);
        check("t4_cnt1", 32'(err_cnt), 1);
        send(7'h0F, 7'h01, 7'h02);
        send(7'h7F, 7'h00, 7'h00);
        send(7'h15, 7'h33, 7'h44);
        send(7'h70, 7'h11, 7'h22);
        in_valid = 1'b0;
        drain();
        check("t4_cnt5", 32'(err_cnt), 5);
        check("t4_sat", 32'(s_err_cnt), 3);

        outs0 = n_out;
        fork
            for (int k = 0; k < 4; k++) send(7'(1 << k), 7'($urandom), 7'($urandom));
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        drain();
        check("t5_count", 32'(n_out - outs0), 4);

        out_ready = 1'b0;
        send(7'h01, 7'h00, 7'h00);
        send(7'h07, 7'h00, 7'h00);
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        outs0 = n_out;
        @(negedge clk);
        check("t6_rst_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_out_valid", 32'(out_valid), 0);
        check("t6_err_cnt", 32'(err_cnt), 0);
        repeat (6) @(negedge clk);
        check("t6_no_emit", 32'(n_out - outs0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
